// File: rtl/sysid_checker_pkg.sv
// Shared definitions for the system-ID checker.
//   - state_t and ST_* : 3-bit FSM state encoding
//   - DEFAULT_EXPECTED_ID / DEFAULT_EXPECTED_TS : build-time reference words
//   - CNT_W : width of the per-transaction timeout counter
package sysid_checker_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ID_REQ  = 3'd1;
  localparam state_t ST_ID_WAIT = 3'd2;
  localparam state_t ST_TS_REQ  = 3'd3;
  localparam state_t ST_TS_WAIT = 3'd4;
  localparam state_t ST_CHECK   = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5185_C227;

  // Sized for the largest legal TIMEOUT_CYCLES (65535).
  localparam int unsigned TIMEOUT_MAX = 65535;
  localparam int unsigned CNT_W       = $clog2(TIMEOUT_MAX + 1);

endpackage

// File: rtl/sysid_checker_timeout.sv
// Per-transaction cycle counter.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the count (wins over enable)
//   enable       : count this cycle
//   limit        : transaction budget in cycles
//   expired      : this is the last cycle of the budget (count == limit-1)
module sysid_checker_timeout
  import sysid_checker_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == (limit - 1'b1));

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 =
// build timestamp) and compares both words with build-time constants.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start                 : one-cycle request to run a check sequence
//   avm_*                 : Avalon-MM read master towards the system-ID slave
//   busy / done           : sequence running / finished (done held until next start)
//   pass, id_match,
//   ts_match, timeout     : result flags, updated together on entry to DONE
//   id_value, ts_value    : captured words
//   retry_count           : retries consumed by the current/last sequence
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_count
);

  localparam logic [CNT_W-1:0] TimeoutLimit = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       MaxRetries   = 4'(MAX_RETRIES);

  state_t state_q, state_d;
  logic   rst_seen_q, kick_q;
  logic   launch, cap_id, cap_ts, do_retry, do_abort;
  logic   tmr_clear, tmr_expired, in_xfer, accept;

  assign in_xfer = (state_q == ST_ID_REQ) || (state_q == ST_ID_WAIT) ||
                   (state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT);
  assign accept  = !avm_waitrequest;

  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    do_retry  = 1'b0;
    do_abort  = 1'b0;
    tmr_clear = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start || kick_q) begin
          launch    = 1'b1;
          tmr_clear = 1'b1;
          state_d   = ST_ID_REQ;
        end
      end
      ST_ID_REQ: begin
        if (accept && avm_readdatavalid) begin
          cap_id    = 1'b1;
          tmr_clear = 1'b1;
          state_d   = ST_TS_REQ;
        end else if (accept) begin
          state_d = ST_ID_WAIT;
        end
      end
      ST_ID_WAIT: begin
        if (avm_readdatavalid) begin
          cap_id    = 1'b1;
          tmr_clear = 1'b1;
          state_d   = ST_TS_REQ;
        end
      end
      ST_TS_REQ: begin
        if (accept && avm_readdatavalid) begin
          cap_ts  = 1'b1;
          state_d = ST_CHECK;
        end else if (accept) begin
          state_d = ST_TS_WAIT;
        end
      end
      ST_TS_WAIT: begin
        if (avm_readdatavalid) begin
          cap_ts  = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    // Data landing in the final budget cycle still counts; only a silent last
    // cycle triggers a retry (always from the ID word) or the abort.
    if (in_xfer && tmr_expired && !(cap_id || cap_ts)) begin
      if (retry_count < MaxRetries) begin
        do_retry  = 1'b1;
        tmr_clear = 1'b1;
        state_d   = ST_ID_REQ;
      end else begin
        do_abort = 1'b1;
        state_d  = ST_DONE;
      end
    end
  end

  sysid_checker_timeout u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (in_xfer),
    .limit   (TimeoutLimit),
    .expired (tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rst_seen_q  <= 1'b1;
      kick_q      <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      retry_count <= '0;
    end else begin
      state_q    <= state_d;
      // Two-stage kick so the auto sequence enters ID_REQ on the second edge
      // after reset is released.
      rst_seen_q <= 1'b0;
      kick_q     <= rst_seen_q & AUTO_START;
      if (launch) begin
        done        <= 1'b0;
        pass        <= 1'b0;
        id_match    <= 1'b0;
        ts_match    <= 1'b0;
        timeout     <= 1'b0;
        id_value    <= '0;
        ts_value    <= '0;
        retry_count <= '0;
      end
      if (cap_id) id_value <= avm_readdata;
      if (cap_ts) ts_value <= avm_readdata;
      if (do_retry) retry_count <= retry_count + 1'b1;
      if (state_q == ST_CHECK) begin
        id_match <= (id_value == EXPECTED_ID);
        ts_match <= (ts_value == EXPECTED_TS);
        pass     <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
        done     <= 1'b1;
      end
      if (do_abort) begin
        done    <= 1'b1;
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

  assign avm_read    = (state_q == ST_ID_REQ) || (state_q == ST_TS_REQ);
  assign avm_address = (state_q == ST_TS_REQ);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_sysid_checker.sv
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID  = 32'h0000_0000;
  localparam logic [31:0] EXP_TS  = 32'h5185_C227;
  localparam int          TMO     = 16;
  localparam int          RETRIES = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, pass, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;
  logic [3:0]  retry_count;

  int n_cmp = 0;
  int n_err = 0;

  // Slave behaviour knobs, set by the test tasks.
  int          cfg_wait  = 0;
  int          cfg_lat   = 0;
  bit          cfg_never = 1'b0;
  logic [31:0] cfg_id    = EXP_ID;
  logic [31:0] cfg_ts    = EXP_TS;
  bit          inj_rdv   = 1'b0;
  logic [31:0] inj_data  = '0;

  // Slave-private state.
  int          stall = 0;
  int          pend  = 0;
  logic [31:0] pend_data = '0;
  logic        acc_addr[$];
  bit          addr_moved = 1'b0;
  logic        prev_wr = 1'b0;
  logic        prev_addr = 1'b0;

  always #5 clock = ~clock;

  sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (RETRIES),
    .AUTO_START     (1'b1)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_match          (id_match),
    .ts_match          (ts_match),
    .timeout           (timeout),
    .id_value          (id_value),
    .ts_value          (ts_value),
    .retry_count       (retry_count)
  );

  // System-ID slave: drives its response for the current cycle at the falling edge.
  always @(negedge clock) begin
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    if (reset) begin
      pend  = 0;
      stall = 0;
    end else if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pend_data;
      end
    end else if (avm_read) begin
      if (prev_wr && (avm_address !== prev_addr)) addr_moved = 1'b1;
      if (stall < cfg_wait) begin
        avm_waitrequest = 1'b1;
        stall = stall + 1;
      end else begin
        stall = 0;
        acc_addr.push_back(avm_address);
        if (!cfg_never) begin
          if (cfg_lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = avm_address ? cfg_ts : cfg_id;
          end else begin
            pend      = cfg_lat;
            pend_data = avm_address ? cfg_ts : cfg_id;
          end
        end
      end
    end else begin
      stall = 0;
    end
    if (inj_rdv) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = inj_data;
    end
    prev_wr   = avm_waitrequest;
    prev_addr = avm_address;
  end

  // Reference latency: two reads of (1 + stall + latency) cycles, plus CHECK
  // and the DONE edge.
  function automatic int exp_cycles(input int w, input int l);
    return 2 + 2 * (1 + w + l);
  endfunction

  // Pulse start and count edges until done (bounded).
  task automatic run_seq(output int cyc);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    int k;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({avm_read, avm_address, busy, done, pass, id_match, ts_match, timeout,
         retry_count, id_value, ts_value} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b read=%b id=%h ts=%h, required all 0",
               busy, done, avm_read, id_value, ts_value);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL auto_first_edge: busy=%b required 0", busy);
    end
    @(posedge clock); #1;
    n_cmp++;
    if ({busy, avm_read, avm_address} !== 3'b110) begin
      n_err++;
      $display("FAIL auto_second_edge: busy/read/addr=%b required 110",
               {busy, avm_read, avm_address});
    end
    k = 0;
    while (!done && k < 300) begin
      @(posedge clock); #1;
      k++;
    end
    n_cmp++;
    if ({done, pass} !== 2'b11 || k != 3) begin
      n_err++;
      $display("FAIL auto_result: done=%b pass=%b after %0d edges, required 1 1 after 3",
               done, pass, k);
    end
  endtask

  task automatic test_zero_latency();
    int cyc, base;
    cfg_wait = 0; cfg_lat = 0; cfg_id = EXP_ID; cfg_ts = EXP_TS;
    base = acc_addr.size();
    run_seq(cyc);
    n_cmp++;
    if (cyc != 4 || {done, pass, id_match, ts_match, timeout} !== 5'b11110) begin
      n_err++;
      $display("FAIL zero_lat_result: cycles=%0d flags=%b, required 4 and 11110",
               cyc, {done, pass, id_match, ts_match, timeout});
    end
    n_cmp++;
    if (acc_addr.size() - base != 2 || acc_addr[base] !== 1'b0 || acc_addr[base+1] !== 1'b1)
    begin
      n_err++;
      $display("FAIL zero_lat_reads: %0d reads issued, required 2 at addresses 0 then 1",
               acc_addr.size() - base);
    end
  endtask

  task automatic test_bad_ts();
    int cyc;
    cfg_ts = 32'h5185_C228;
    run_seq(cyc);
    n_cmp++;
    if (cyc != 4 || {done, id_match, ts_match, pass} !== 4'b1100 ||
        ts_value !== 32'h5185_C228) begin
      n_err++;
      $display("FAIL bad_ts: cycles=%0d done/idm/tsm/pass=%b ts=%h, required 4 1100 5185c228",
               cyc, {done, id_match, ts_match, pass}, ts_value);
    end
    cfg_ts = EXP_TS;
  endtask

  task automatic test_stall();
    int cyc;
    cfg_wait = 5; cfg_lat = 3; addr_moved = 1'b0;
    run_seq(cyc);
    n_cmp++;
    if (cyc != exp_cycles(5, 3) || pass !== 1'b1) begin
      n_err++;
      $display("FAIL stall_timing: cycles=%0d pass=%b, required %0d and 1",
               cyc, pass, exp_cycles(5, 3));
    end
    n_cmp++;
    if (addr_moved) begin
      n_err++;
      $display("FAIL stall_addr_stable: address changed under waitrequest, required stable");
    end
  endtask

  // Read completing in the very last cycle of the budget must be accepted.
  task automatic test_boundary();
    int cyc;
    cfg_wait = 0; cfg_lat = TMO - 1;
    run_seq(cyc);
    n_cmp++;
    if (cyc != exp_cycles(0, TMO - 1) || {pass, timeout} !== 2'b10 || retry_count !== 4'd0) begin
      n_err++;
      $display("FAIL budget_edge: cycles=%0d pass=%b timeout=%b retries=%0d, required %0d 1 0 0",
               cyc, pass, timeout, retry_count, exp_cycles(0, TMO - 1));
    end
  endtask

  task automatic test_random();
    int cyc, w, l;
    logic [31:0] rid, rts;
    for (int i = 0; i < 10; i++) begin
      w = $urandom_range(0, 6);
      l = $urandom_range(0, 6);
      rid = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      rts = ($urandom_range(0, 1) == 1) ? EXP_TS : (EXP_TS ^ (32'h1 << $urandom_range(0, 31)));
      cfg_wait = w; cfg_lat = l; cfg_id = rid; cfg_ts = rts;
      run_seq(cyc);
      n_cmp++;
      if (cyc != exp_cycles(w, l) || id_value !== rid || ts_value !== rts ||
          id_match !== (rid == EXP_ID) || ts_match !== (rts == EXP_TS) ||
          pass !== ((rid == EXP_ID) && (rts == EXP_TS)) || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL random_%0d: w=%0d l=%0d cycles=%0d id=%h ts=%h idm=%b tsm=%b pass=%b, required cycles=%0d id=%h ts=%h",
                 i, w, l, cyc, id_value, ts_value, id_match, ts_match, pass,
                 exp_cycles(w, l), rid, rts);
      end
    end
    cfg_id = EXP_ID; cfg_ts = EXP_TS;
  endtask

  task automatic test_timeout();
    int cyc, base;
    bit all_id;
    cfg_wait = 0; cfg_lat = 0; cfg_never = 1'b1;
    base = acc_addr.size();
    run_seq(cyc);
    n_cmp++;
    if (cyc != 1 + (RETRIES + 1) * TMO || {done, timeout, pass} !== 3'b110 ||
        retry_count !== 4'(RETRIES)) begin
      n_err++;
      $display("FAIL timeout_result: cycles=%0d done/timeout/pass=%b retries=%0d, required %0d 110 %0d",
               cyc, {done, timeout, pass}, retry_count, 1 + (RETRIES + 1) * TMO, RETRIES);
    end
    all_id = 1'b1;
    for (int i = base; i < acc_addr.size(); i++) if (acc_addr[i] !== 1'b0) all_id = 1'b0;
    n_cmp++;
    if (acc_addr.size() - base != RETRIES + 1 || !all_id) begin
      n_err++;
      $display("FAIL timeout_attempts: %0d reads (all_id=%b), required %0d ID reads",
               acc_addr.size() - base, all_id, RETRIES + 1);
    end
    cfg_never = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k, base;
    cfg_wait = 0; cfg_lat = 4;
    base = acc_addr.size();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    k = 0;
    while (acc_addr.size() - base < 2 && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    n_cmp++;
    if (acc_addr.size() - base != 2) begin
      n_err++;
      $display("FAIL midreset_reach_ts_wait: %0d reads seen, required 2", acc_addr.size() - base);
    end
    // Now in TS_WAIT with the timestamp response outstanding.
    reset = 1'b1;
    cfg_lat = 0;
    @(posedge clock); #1 reset = 1'b0;
    n_cmp++;
    if ({avm_read, avm_address, busy, done, pass, id_match, ts_match, timeout,
         retry_count, id_value, ts_value} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: read=%b busy=%b done=%b id=%h ts=%h, required all 0",
               avm_read, busy, done, id_value, ts_value);
    end
    inj_data = 32'hBAD0_0001;
    inj_rdv  = 1'b1;
    @(posedge clock); #1 inj_rdv = 1'b0;
    n_cmp++;
    if (id_value !== 32'h0 || ts_value !== 32'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_late_data: id=%h ts=%h busy=%b, required 0 0 0",
               id_value, ts_value, busy);
    end
    k = 0;
    while (!done && k < 300) begin
      @(posedge clock); #1;
      k++;
    end
    n_cmp++;
    if (k != 4 || pass !== 1'b1 || ts_value !== EXP_TS) begin
      n_err++;
      $display("FAIL midreset_autorerun: %0d edges pass=%b ts=%h, required 4 1 %h",
               k, pass, ts_value, EXP_TS);
    end
  endtask

  task automatic test_ignored();
    int cyc, base;
    cfg_wait = 0; cfg_lat = 3;
    base = acc_addr.size();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      start = (cyc == 2);
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (cyc != exp_cycles(0, 3) || acc_addr.size() - base != 2 || pass !== 1'b1) begin
      n_err++;
      $display("FAIL start_while_busy: cycles=%0d reads=%0d pass=%b, required %0d 2 1",
               cyc, acc_addr.size() - base, pass, exp_cycles(0, 3));
    end
    inj_data = 32'hFFFF_0000;
    inj_rdv  = 1'b1;
    repeat (2) @(posedge clock);
    #1 inj_rdv = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (id_value !== EXP_ID || ts_value !== EXP_TS || {done, pass, busy} !== 3'b110) begin
      n_err++;
      $display("FAIL idle_rdv_ignored: id=%h ts=%h done/pass/busy=%b, required %h %h 110",
               id_value, ts_value, {done, pass, busy}, EXP_ID, EXP_TS);
    end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_bad_ts();
    test_stall();
    test_boundary();
    test_random();
    test_timeout();
    test_reset_mid();
    test_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
